// File: rtl/pwr_seq_pkg.sv
// Shared types and constants for the pwr_seq power sequencer.
// State width grows to 3 bits when PWR_SEQ_PGOOD_EN adds the FAULT state.
package pwr_seq_pkg;

`ifdef PWR_SEQ_PGOOD_EN
  localparam int STATE_W = 3;
`else
  localparam int STATE_W = 2;
`endif

  localparam int DEF_ON_DLY     = 10000;
  localparam int DEF_OFF_DLY    = 5000;
  localparam int DEF_CTR_W      = 14;
  localparam int DEF_PG_TIMEOUT = 50000;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF   = STATE_W'(0),
    ST_RAMP  = STATE_W'(1),
    ST_ON    = STATE_W'(2),
    ST_DRAIN = STATE_W'(3)
`ifdef PWR_SEQ_PGOOD_EN
    ,
    ST_FAULT = STATE_W'(4)
`endif
  } state_e;

  typedef struct packed {
    logic pwr_ena;
    logic tri_z;
    logic busy;
`ifdef PWR_SEQ_PGOOD_EN
    logic fault;
`endif
  } out_s;

  // Output levels are a pure function of state; tri_z is 1 in every state
  // except ON, so the peripheral is never driven while unpowered.
  function automatic out_s decode(input state_e s);
    out_s o;
    o.pwr_ena = (s == ST_RAMP) || (s == ST_ON) || (s == ST_DRAIN);
    o.tri_z   = (s != ST_ON);
    o.busy    = (s == ST_RAMP) || (s == ST_DRAIN);
`ifdef PWR_SEQ_PGOOD_EN
    o.fault   = (s == ST_FAULT);
`endif
    return o;
  endfunction

endpackage

// File: rtl/pwr_seq_ctr.sv
// Loadable saturating down-counter with a "count is one" flag.
// Clear wins over load, load wins over decrement; it never wraps below zero.
module pwr_seq_ctr #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         one_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every variable written in always_comb gets a default on entry;
  // a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign one_o = (cnt_q == W'(1));

endmodule

// File: rtl/pwr_seq.sv
// Peripheral power sequencer: OFF -> RAMP -> ON -> DRAIN with registered outputs.
// Define PWR_SEQ_PGOOD_EN to add pwr_good supervision, a RAMP timeout and a FAULT state.
module pwr_seq
  import pwr_seq_pkg::*;
#(
  parameter int ON_DLY  = DEF_ON_DLY,
  parameter int OFF_DLY = DEF_OFF_DLY,
  parameter int CTR_W   = DEF_CTR_W
`ifdef PWR_SEQ_PGOOD_EN
  ,
  parameter int PG_TIMEOUT = DEF_PG_TIMEOUT
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_req_i,
`ifdef PWR_SEQ_PGOOD_EN
  input  logic               pwr_good_i,
  output logic               fault_o,
`endif
  output logic               pwr_ena_o,
  output logic               tri_o,
  output logic               busy_o,
  output logic [STATE_W-1:0] state_o
);

  if (ON_DLY < 1 || ON_DLY > (2 ** CTR_W) - 1) begin : g_bad_on_dly
    $error("pwr_seq: ON_DLY must be in 1 .. 2**CTR_W-1");
  end
  if (OFF_DLY < 1 || OFF_DLY > (2 ** CTR_W) - 1) begin : g_bad_off_dly
    $error("pwr_seq: OFF_DLY must be in 1 .. 2**CTR_W-1");
  end

  state_e           state_q, state_d;
  state_e           state_out_q;
  out_s             out_q;
  logic             ctr_clr, ctr_load, ctr_dec, ctr_one;
  logic [CTR_W-1:0] ctr_val;

`ifdef PWR_SEQ_PGOOD_EN
  localparam int TO_W = $clog2(PG_TIMEOUT + 1);

  if (PG_TIMEOUT < 1) begin : g_bad_pg_timeout
    $error("pwr_seq: PG_TIMEOUT must be >= 1");
  end

  logic to_clr, to_load, to_dec, to_one;
  logic pg_seen_q, pg_seen_d, pg_started;

  // The ON_DLY countdown is armed by the first pwr_good seen in RAMP.
  assign pg_started = pg_seen_q | pwr_good_i;
`endif

  always_comb begin
    state_d  = state_q;
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    ctr_val  = '0;
`ifdef PWR_SEQ_PGOOD_EN
    to_clr    = 1'b0;
    to_load   = 1'b0;
    to_dec    = 1'b0;
    pg_seen_d = pg_seen_q;
`endif

    unique case (state_q)
      ST_OFF: begin
        if (ena_req_i) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (!ena_req_i) begin
          state_d = ST_OFF;
`ifdef PWR_SEQ_PGOOD_EN
        end else if (!pg_started) begin
          if (to_one) state_d = ST_FAULT;
          else        to_dec  = 1'b1;
        end else begin
          pg_seen_d = 1'b1;
          if (ctr_one) state_d = ST_ON;
          else         ctr_dec = 1'b1;
        end
`else
        end else if (ctr_one) begin
          state_d = ST_ON;
        end else begin
          ctr_dec = 1'b1;
        end
`endif
      end
      ST_ON: begin
`ifdef PWR_SEQ_PGOOD_EN
        if (!pwr_good_i)     state_d = ST_FAULT;
        else if (!ena_req_i) state_d = ST_DRAIN;
`else
        if (!ena_req_i) state_d = ST_DRAIN;
`endif
      end
      ST_DRAIN: begin
        if (ctr_one) state_d = ST_OFF;
        else         ctr_dec = 1'b1;
      end
`ifdef PWR_SEQ_PGOOD_EN
      ST_FAULT: begin
        if (!ena_req_i) state_d = ST_OFF;
      end
`endif
      default: state_d = ST_OFF;
    endcase

    // Counters are reloaded on every state entry and sit at zero elsewhere.
    if (state_d != state_q) begin
      case (state_d)
        ST_RAMP: begin
          ctr_load = 1'b1;
          ctr_val  = CTR_W'(ON_DLY);
        end
        ST_DRAIN: begin
          ctr_load = 1'b1;
          ctr_val  = CTR_W'(OFF_DLY);
        end
        default: ctr_clr = 1'b1;
      endcase
`ifdef PWR_SEQ_PGOOD_EN
      pg_seen_d = 1'b0;
      to_load   = (state_d == ST_RAMP);
      to_clr    = (state_d != ST_RAMP);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      state_out_q <= ST_OFF;
      out_q       <= decode(ST_OFF);
    end else begin
      state_q     <= state_d;
      state_out_q <= state_q;
      out_q       <= decode(state_q);
    end
  end

  pwr_seq_ctr #(.W(CTR_W)) u_dly_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (ctr_clr),
    .load_i     (ctr_load),
    .dec_i      (ctr_dec),
    .load_val_i (ctr_val),
    .one_o      (ctr_one)
  );

`ifdef PWR_SEQ_PGOOD_EN
  always_ff @(posedge clk) begin
    if (rst) pg_seen_q <= 1'b0;
    else     pg_seen_q <= pg_seen_d;
  end

  pwr_seq_ctr #(.W(TO_W)) u_to_ctr (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (to_clr),
    .load_i     (to_load),
    .dec_i      (to_dec),
    .load_val_i (TO_W'(PG_TIMEOUT)),
    .one_o      (to_one)
  );

  assign fault_o = out_q.fault;
`endif

  assign pwr_ena_o = out_q.pwr_ena;
  assign tri_o     = out_q.tri_z;
  assign busy_o    = out_q.busy;
  assign state_o   = state_out_q;

endmodule

// File: tb/tb_pwr_seq.sv
// Scoreboard bench for pwr_seq: a deadline-based model predicts outputs per edge,
// a separate monitor pops and compares them after each rising edge.
module tb_pwr_seq;
  import pwr_seq_pkg::*;

  localparam int ON_DLY     = 10;
  localparam int OFF_DLY    = 5;
  localparam int PG_TIMEOUT = 20;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ena_req = 1'b0;
  logic               pwr_ena, tri_z, busy;
  logic [STATE_W-1:0] state;
`ifdef PWR_SEQ_PGOOD_EN
  logic               pwr_good = 1'b1;
  logic               fault;
`endif

  always #5 clk = ~clk;

  pwr_seq #(
    .ON_DLY     (ON_DLY),
    .OFF_DLY    (OFF_DLY),
    .CTR_W      (14)
`ifdef PWR_SEQ_PGOOD_EN
    ,
    .PG_TIMEOUT (PG_TIMEOUT)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena_req_i  (ena_req),
`ifdef PWR_SEQ_PGOOD_EN
    .pwr_good_i (pwr_good),
    .fault_o    (fault),
`endif
    .pwr_ena_o  (pwr_ena),
    .tri_o      (tri_z),
    .busy_o     (busy),
    .state_o    (state)
  );

  typedef enum int {M_OFF, M_RAMP, M_ON, M_DRAIN, M_FAULT} mphase_e;
  typedef struct {
    int   edge_no;
    logic pwr_ena;
    logic tri_z;
    logic busy;
    logic fault;
    logic [7:0] st;
  } exp_t;

  exp_t    exp_q[$];
  int      n_vec = 0;
  int      n_bad = 0;

  // Model: phase plus absolute edge numbers at which timed transitions fire.
  mphase_e ph = M_OFF;
  int      edge_cnt = 0;
  int      on_at = 0, off_at = 0, fault_at = 0;
  bit      started = 1'b0;

  function automatic exp_t expect_of(input mphase_e p, input int e);
    exp_t x;
    x.edge_no = e;
    x.pwr_ena = 1'b0; x.tri_z = 1'b1; x.busy = 1'b0; x.fault = 1'b0; x.st = 8'd0;
    case (p)
      M_OFF:   x.st = 8'd0;
      M_RAMP:  begin x.pwr_ena = 1'b1; x.busy = 1'b1; x.st = 8'd1; end
      M_ON:    begin x.pwr_ena = 1'b1; x.tri_z = 1'b0; x.st = 8'd2; end
      M_DRAIN: begin x.pwr_ena = 1'b1; x.busy = 1'b1; x.st = 8'd3; end
      M_FAULT: begin x.fault = 1'b1; x.st = 8'd4; end
      default: x.st = 8'd0;
    endcase
    return x;
  endfunction

  // Called just before each rising edge with the inputs already applied.
  // Outputs after edge e reflect the phase held before edge e (or reset).
  task automatic model_step();
    exp_q.push_back(expect_of(rst ? M_OFF : ph, edge_cnt));
    if (rst) begin
      ph = M_OFF;
    end else begin
      case (ph)
        M_OFF: if (ena_req) begin
          ph       = M_RAMP;
          on_at    = edge_cnt + ON_DLY;
          fault_at = edge_cnt + PG_TIMEOUT;
          started  = 1'b0;
        end
        M_RAMP: begin
          if (!ena_req) ph = M_OFF;
`ifdef PWR_SEQ_PGOOD_EN
          else if (!started && !pwr_good) begin
            if (edge_cnt == fault_at) ph = M_FAULT;
          end else begin
            if (!started) begin
              started = 1'b1;
              on_at   = edge_cnt + ON_DLY - 1;
            end
            if (edge_cnt == on_at) ph = M_ON;
          end
`else
          else if (edge_cnt == on_at) ph = M_ON;
`endif
        end
        M_ON: begin
`ifdef PWR_SEQ_PGOOD_EN
          if (!pwr_good) ph = M_FAULT;
          else
`endif
          if (!ena_req) begin
            ph     = M_DRAIN;
            off_at = edge_cnt + OFF_DLY;
          end
        end
        M_DRAIN: if (edge_cnt == off_at) ph = M_OFF;
        M_FAULT: if (!ena_req) ph = M_OFF;
        default: ph = M_OFF;
      endcase
    end
    edge_cnt++;
  endtask

  task automatic check(input string nm, input int e, input logic [7:0] got,
                       input logic [7:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, e, got, want);
    end
  endtask

  task automatic run(input int n, input bit r, input bit e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst     = r;
      ena_req = e;
      model_step();
    end
  endtask

  // Monitor: one expected record per rising edge, checked 1 ns after it.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("pwr_ena", x.edge_no, 8'(pwr_ena), 8'(x.pwr_ena));
        check("tri",     x.edge_no, 8'(tri_z),   8'(x.tri_z));
        check("busy",    x.edge_no, 8'(busy),    8'(x.busy));
        check("state",   x.edge_no, 8'(state),   x.st);
`ifdef PWR_SEQ_PGOOD_EN
        check("fault",   x.edge_no, 8'(fault),   8'(x.fault));
`endif
        check("tri_when_unpowered", x.edge_no, 8'(tri_z | pwr_ena), 8'd1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ena_v;
    bit rst_v;

    run(2, 1'b1, 1'b0);                         // reset
    run(3, 1'b0, 1'b0);
    run(25, 1'b0, 1'b1);                        // power-up to ON
    run(10, 1'b0, 1'b0);                        // power-down through DRAIN
    run(5, 1'b0, 1'b1);                         // abort mid-RAMP
    run(5, 1'b0, 1'b0);
    run(15, 1'b0, 1'b1);
    run(2, 1'b0, 1'b0);                         // enter DRAIN
    run(25, 1'b0, 1'b1);                        // re-raise during DRAIN, reach ON
    run(1, 1'b1, 1'b1);                         // reset while ON
    run(15, 1'b0, 1'b1);
    run(10, 1'b0, 1'b0);

`ifdef PWR_SEQ_PGOOD_EN
    pwr_good = 1'b0;
    run(25, 1'b0, 1'b1);                        // RAMP timeout -> FAULT
    run(3, 1'b0, 1'b0);                         // FAULT -> OFF
    run(5, 1'b0, 1'b1);
    pwr_good = 1'b1;                            // late pwr_good arms countdown
    run(15, 1'b0, 1'b1);
    pwr_good = 1'b0;                            // loss of pwr_good while ON
    run(3, 1'b0, 1'b1);
    run(3, 1'b0, 1'b0);
    pwr_good = 1'b1;
`endif

    ena_v = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 11) == 0) ena_v = ~ena_v;
      rst_v = ($urandom_range(0, 299) == 0);
`ifdef PWR_SEQ_PGOOD_EN
      if (pwr_good) pwr_good = ($urandom_range(0, 59) != 0);
      else          pwr_good = ($urandom_range(0, 3) == 0);
`endif
      run(1, rst_v, ena_v);
    end
    run(3, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", edge_cnt, 8'(exp_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
